// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider (DIV/DIVU) with pipeline stall request and flush cancel
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               annul,
  output logic               stall_divE,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_n, quo_n, a_mag, b_mag;
  always_comb begin
    a_mag = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    b_mag = (signed_div && opb[WIDTH-1]) ? -opb : opb;
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    // a negative trial means the shifted partial is below the divisor, so it still fits WIDTH bits
    rem_n = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_n = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (annul)
      state_d = FREE;
    else
      case (state_q)
        FREE: if (startE) begin
          state_d = (opb == '0) ? BYZERO : ON;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          negq_d  = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          negr_d  = signed_div & opa[WIDTH-1];
        end
        ON: begin
          cnt_d = cnt_q + CW'(1);
          rem_d = rem_n;
          quo_d = quo_n;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = END;
            result_d = {negr_q ? -rem_n : rem_n, negq_q ? -quo_n : quo_n};
          end
        end
        BYZERO: begin
          state_d  = END;
          result_d = '0;
        end
        default: state_d = FREE;
      endcase
    stall_divE = ~annul & ((state_q == FREE & startE) | state_q == ON | state_q == BYZERO);
    ready      = ~annul & (state_q == END);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end
  assign result = result_q;
endmodule
